// File: rtl/dense_pkg.sv
// rtl/dense_pkg.sv - shared types, layer-2 defaults and read-count helper for dense sequencers
package dense_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } dense_state_e;

  localparam int L2_N_IN       = 16;
  localparam int L2_N_OUT      = 10;
  localparam int L2_ADDR_WIDTH = 8;

  function automatic int total_reads(input int n_in, input int n_out, input bit bias);
    return bias ? n_out * (n_in + 1) : n_in * n_out;
  endfunction

endpackage

// File: rtl/dense_w2_resp_pipe.sv
// rtl/dense_w2_resp_pipe.sv - one-stage register aligning MAC control and indices with ROM read latency
module dense_w2_resp_pipe #(
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid,
  input  logic             first,
  input  logic             last,
  input  logic [IDX_W-1:0] act,
  input  logic [IDX_W-1:0] neuron,
  output logic             mac_valid,
  output logic             mac_first,
  output logic             mac_last,
  output logic [IDX_W-1:0] act_idx,
  output logic [IDX_W-1:0] neuron_idx
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mac_valid  <= 1'b0;
      mac_first  <= 1'b0;
      mac_last   <= 1'b0;
      act_idx    <= '0;
      neuron_idx <= '0;
    end else begin
      mac_valid  <= valid;
      mac_first  <= first;
      mac_last   <= last;
      act_idx    <= act;
      neuron_idx <= neuron;
    end
  end

endmodule

// File: rtl/dense_w2_seq.sv
// rtl/dense_w2_seq.sv - neuron-major read sequencer for the layer-2 weight ROM
// Optional feature: DENSE_W2_SEQ_BIAS_EN adds one bias read per neuron.
module dense_w2_seq
  import dense_pkg::*;
#(
  parameter int ADDR_WIDTH = L2_ADDR_WIDTH,
  parameter int N_IN       = L2_N_IN,
  parameter int N_OUT      = L2_N_OUT,
  parameter int IDX_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  hold,
  output logic                  busy,
  output logic                  done,
  output logic                  rom_ena,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  mac_valid,
  output logic                  mac_first,
  output logic                  mac_last,
  output logic [IDX_W-1:0]      act_idx,
  output logic [IDX_W-1:0]      neuron_idx
);

`ifdef DENSE_W2_SEQ_BIAS_EN
  localparam bit BIAS = 1'b1;
`else
  localparam bit BIAS = 1'b0;
`endif

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] RUN   = ST_RUN;
  localparam logic [1:0] DRAIN = ST_DRAIN;
  localparam logic [1:0] DONE  = ST_DONE;

  // i_cnt == N_IN marks the bias slot of a neuron when bias reads are enabled
  localparam logic [IDX_W-1:0]      I_BIAS    = IDX_W'(N_IN);
  localparam logic [IDX_W-1:0]      I_LAST    = BIAS ? IDX_W'(N_IN) : IDX_W'(N_IN - 1);
  localparam logic [IDX_W-1:0]      N_LAST    = IDX_W'(N_OUT - 1);
  localparam logic [ADDR_WIDTH-1:0] BIAS_BASE = ADDR_WIDTH'(N_IN * N_OUT);

  if (total_reads(N_IN, N_OUT, BIAS) > (2 ** ADDR_WIDTH)) begin : g_size_check
    $error("dense_w2_seq: ROM address space too small for N_IN*N_OUT reads");
  end

  logic [1:0]            state;
  logic [IDX_W-1:0]      i_cnt;
  logic [IDX_W-1:0]      n_cnt;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [ADDR_WIDTH-1:0] baddr;
  logic                  issue;
  logic                  in_bias;
  logic                  last_read;

  assign issue     = (state == RUN) && !hold;
  assign in_bias   = BIAS && (i_cnt == I_BIAS);
  assign last_read = (i_cnt == I_LAST) && (n_cnt == N_LAST);

  assign rom_ena  = issue;
  assign rom_addr = in_bias ? baddr : waddr;
  assign busy     = (state == RUN) || (state == DRAIN);
  assign done     = (state == DONE);

  // Weight and bias addresses are separate running registers so the weight
  // stream resumes exactly where it left off after each bias read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      i_cnt <= '0;
      n_cnt <= '0;
      waddr <= '0;
      baddr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            i_cnt <= '0;
            n_cnt <= '0;
            waddr <= '0;
            baddr <= BIAS_BASE;
          end
        end
        RUN: begin
          if (!hold) begin
            if (last_read) begin
              state <= DRAIN;
            end else if (i_cnt == I_LAST) begin
              i_cnt <= '0;
              n_cnt <= n_cnt + IDX_W'(1);
              baddr <= baddr + ADDR_WIDTH'(1);
            end else begin
              i_cnt <= i_cnt + IDX_W'(1);
            end
            if (!in_bias) waddr <= waddr + ADDR_WIDTH'(1);
          end
        end
        DRAIN:   state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  dense_w2_resp_pipe #(.IDX_W(IDX_W)) u_resp_pipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid      (issue),
    .first      (issue && (i_cnt == '0)),
    .last       (issue && (i_cnt == I_LAST)),
    .act        (i_cnt),
    .neuron     (n_cnt),
    .mac_valid  (mac_valid),
    .mac_first  (mac_first),
    .mac_last   (mac_last),
    .act_idx    (act_idx),
    .neuron_idx (neuron_idx)
  );

endmodule

// File: tb/tb_dense_w2_seq.sv
// tb/tb_dense_w2_seq.sv - directed table and scoreboard bench for dense_w2_seq
module tb_dense_w2_seq;

`ifdef DENSE_W2_SEQ_BIAS_EN
  localparam int EXP_DONE_K   = 12;
  localparam int BIG_READS    = 170;
  localparam int BIG_LAST_ACT = 16;
`else
  localparam int EXP_DONE_K   = 10;
  localparam int BIG_READS    = 160;
  localparam int BIG_LAST_ACT = 15;
`endif

  typedef struct {
    logic start, hold, ena;
    int   addr;
    logic valid, first, last, done, busy;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic start, hold, busy, done, rom_ena, mac_valid, mac_first, mac_last;
  logic [7:0] rom_addr, act_idx, neuron_idx;
  logic b_start, b_hold, b_busy, b_done, b_rom_ena, b_mac_valid, b_mac_first, b_mac_last;
  logic [7:0] b_rom_addr, b_act_idx, b_neuron_idx, b_q;
  logic [7:0] rom [256];

  int checks = 0;
  int errors = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  dense_w2_seq #(.ADDR_WIDTH(8), .N_IN(4), .N_OUT(2), .IDX_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .hold(hold), .busy(busy), .done(done),
    .rom_ena(rom_ena), .rom_addr(rom_addr), .mac_valid(mac_valid), .mac_first(mac_first),
    .mac_last(mac_last), .act_idx(act_idx), .neuron_idx(neuron_idx)
  );

  dense_w2_seq u_big (
    .clk(clk), .rst_n(rst_n), .start(b_start), .hold(b_hold), .busy(b_busy), .done(b_done),
    .rom_ena(b_rom_ena), .rom_addr(b_rom_addr), .mac_valid(b_mac_valid), .mac_first(b_mac_first),
    .mac_last(b_mac_last), .act_idx(b_act_idx), .neuron_idx(b_neuron_idx)
  );

  // Weight ROM model: one-cycle read latency, returns 0 when not enabled
  always @(posedge clk) b_q <= b_rom_ena ? rom[b_rom_addr] : 8'd0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input bit s, input bit h, input bit e, input int a,
                              input bit v, input bit f, input bit l, input bit d, input bit b);
    vec_t r;
    r.start = s; r.hold = h; r.ena = e; r.addr = a;
    r.valid = v; r.first = f; r.last = l; r.done = d; r.busy = b;
    return r;
  endfunction

  task automatic run_tbl(input string nm);
    foreach (tbl[k]) begin
      start = tbl[k].start;
      hold  = tbl[k].hold;
      @(negedge clk);
      chk($sformatf("%s c%0d rom_ena", nm, k), rom_ena, tbl[k].ena);
      if (tbl[k].ena) chk($sformatf("%s c%0d rom_addr", nm, k), rom_addr, tbl[k].addr);
      chk($sformatf("%s c%0d mac_valid", nm, k), mac_valid, tbl[k].valid);
      chk($sformatf("%s c%0d mac_first", nm, k), mac_first, tbl[k].first);
      chk($sformatf("%s c%0d mac_last", nm, k), mac_last, tbl[k].last);
      chk($sformatf("%s c%0d done", nm, k), done, tbl[k].done);
      chk($sformatf("%s c%0d busy", nm, k), busy, tbl[k].busy);
      @(posedge clk); #1;
    end
    start = 1'b0;
    hold  = 1'b0;
  endtask

  task automatic fill_basic();
    tbl.delete();
`ifdef DENSE_W2_SEQ_BIAS_EN
    tbl.push_back(mk(1,0,0,0, 0,0,0,0,0));
    tbl.push_back(mk(0,0,1,0, 0,0,0,0,1));
    tbl.push_back(mk(0,0,1,1, 1,1,0,0,1));
    tbl.push_back(mk(0,0,1,2, 1,0,0,0,1));
    tbl.push_back(mk(0,0,1,3, 1,0,0,0,1));
    tbl.push_back(mk(0,0,1,8, 1,0,0,0,1));
    tbl.push_back(mk(0,0,1,4, 1,0,1,0,1));
    tbl.push_back(mk(0,0,1,5, 1,1,0,0,1));
    tbl.push_back(mk(0,0,1,6, 1,0,0,0,1));
    tbl.push_back(mk(0,0,1,7, 1,0,0,0,1));
    tbl.push_back(mk(0,0,1,9, 1,0,0,0,1));
    tbl.push_back(mk(0,0,0,0, 1,0,1,0,1));
    tbl.push_back(mk(0,0,0,0, 0,0,0,1,0));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0,0));
`else
    tbl.push_back(mk(1,0,0,0, 0,0,0,0,0));
    tbl.push_back(mk(0,0,1,0, 0,0,0,0,1));
    tbl.push_back(mk(0,0,1,1, 1,1,0,0,1));
    tbl.push_back(mk(0,0,1,2, 1,0,0,0,1));
    tbl.push_back(mk(0,0,1,3, 1,0,0,0,1));
    tbl.push_back(mk(0,0,1,4, 1,0,1,0,1));
    tbl.push_back(mk(0,0,1,5, 1,1,0,0,1));
    tbl.push_back(mk(0,0,1,6, 1,0,0,0,1));
    tbl.push_back(mk(0,0,1,7, 1,0,0,0,1));
    tbl.push_back(mk(0,0,0,0, 1,0,1,0,1));
    tbl.push_back(mk(0,0,0,0, 0,0,0,1,0));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0,0));
`endif
  endtask

  task automatic fill_hold();
    tbl.delete();
`ifdef DENSE_W2_SEQ_BIAS_EN
    tbl.push_back(mk(1,0,0,0, 0,0,0,0,0));
    tbl.push_back(mk(0,0,1,0, 0,0,0,0,1));
    tbl.push_back(mk(0,0,1,1, 1,1,0,0,1));
    tbl.push_back(mk(0,1,0,0, 1,0,0,0,1));
    tbl.push_back(mk(0,1,0,0, 0,0,0,0,1));
    tbl.push_back(mk(0,0,1,2, 0,0,0,0,1));
    tbl.push_back(mk(0,0,1,3, 1,0,0,0,1));
    tbl.push_back(mk(0,0,1,8, 1,0,0,0,1));
    tbl.push_back(mk(0,0,1,4, 1,0,1,0,1));
    tbl.push_back(mk(0,0,1,5, 1,1,0,0,1));
    tbl.push_back(mk(0,0,1,6, 1,0,0,0,1));
    tbl.push_back(mk(0,0,1,7, 1,0,0,0,1));
    tbl.push_back(mk(0,0,1,9, 1,0,0,0,1));
    tbl.push_back(mk(0,1,0,0, 1,0,1,0,1));
    tbl.push_back(mk(0,1,0,0, 0,0,0,1,0));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0,0));
`else
    tbl.push_back(mk(1,0,0,0, 0,0,0,0,0));
    tbl.push_back(mk(0,0,1,0, 0,0,0,0,1));
    tbl.push_back(mk(0,0,1,1, 1,1,0,0,1));
    tbl.push_back(mk(0,1,0,0, 1,0,0,0,1));
    tbl.push_back(mk(0,1,0,0, 0,0,0,0,1));
    tbl.push_back(mk(0,0,1,2, 0,0,0,0,1));
    tbl.push_back(mk(0,0,1,3, 1,0,0,0,1));
    tbl.push_back(mk(0,0,1,4, 1,0,1,0,1));
    tbl.push_back(mk(0,0,1,5, 1,1,0,0,1));
    tbl.push_back(mk(0,0,1,6, 1,0,0,0,1));
    tbl.push_back(mk(0,0,1,7, 1,0,0,0,1));
    tbl.push_back(mk(0,1,0,0, 1,0,1,0,1));
    tbl.push_back(mk(0,1,0,0, 0,0,0,1,0));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0,0));
`endif
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, " busy"}, busy, 0);
    chk({nm, " done"}, done, 0);
    chk({nm, " rom_ena"}, rom_ena, 0);
    chk({nm, " rom_addr"}, rom_addr, 0);
    chk({nm, " mac_valid"}, mac_valid, 0);
    chk({nm, " mac_first"}, mac_first, 0);
    chk({nm, " mac_last"}, mac_last, 0);
    chk({nm, " act_idx"}, act_idx, 0);
    chk({nm, " neuron_idx"}, neuron_idx, 0);
  endtask

  initial begin
    int dn, done_k, bz_after, vcnt, lastcnt, firstcnt, bad_act;
    bit seen, fin;
    int sum [10];
    int ref_sum [10];

    for (int a = 0; a < 256; a++) rom[a] = 8'((a * 37 + 11) % 256);
    rst_n = 1'b0; start = 1'b0; hold = 1'b0; b_start = 1'b0; b_hold = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    fill_basic();
    run_tbl("basic");
    fill_hold();
    run_tbl("hold");

    // start re-pulsed while busy and in the done cycle must be ignored
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dn = 0; done_k = -1; bz_after = 0; seen = 1'b0;
    for (int k = 1; k < 40; k++) begin
      start = (k == 3);
      @(negedge clk);
      if (done) begin
        dn++;
        done_k = k;
        start = 1'b1;
        seen = 1'b1;
      end else if (seen && busy) begin
        bz_after++;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk("restart done count", dn, 1);
    chk("restart done cycle", done_k, EXP_DONE_K);
    chk("restart busy after done", bz_after, 0);

    // asynchronous reset in the middle of a run
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrun reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    dn = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done || busy) dn++;
      @(posedge clk); #1;
    end
    chk("aborted run activity", dn, 0);
    fill_basic();
    run_tbl("after reset");

    // default-size run under random hold, scoreboarded against the ROM model
    for (int n = 0; n < 10; n++) begin
      sum[n] = 0;
      ref_sum[n] = 0;
      for (int i = 0; i < 16; i++) ref_sum[n] += rom[n * 16 + i];
`ifdef DENSE_W2_SEQ_BIAS_EN
      ref_sum[n] += rom[160 + n];
`endif
    end
    vcnt = 0; lastcnt = 0; firstcnt = 0; bad_act = 0; fin = 1'b0;
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
      b_hold = ($urandom_range(0, 99) < 30);
      @(negedge clk);
      if (b_mac_valid) begin
        vcnt++;
        if (b_neuron_idx < 10) sum[b_neuron_idx] += b_q;
        if (b_mac_first) firstcnt++;
        if (b_mac_last) begin
          lastcnt++;
          if (b_act_idx != BIG_LAST_ACT) bad_act++;
        end
      end
      if (b_done) fin = 1'b1;
      @(posedge clk); #1;
    end
    b_hold = 1'b0;
    chk("random done reached", fin, 1);
    chk("random mac_valid count", vcnt, BIG_READS);
    chk("random mac_first count", firstcnt, 10);
    chk("random mac_last count", lastcnt, 10);
    chk("random last act_idx", bad_act, 0);
    for (int n = 0; n < 10; n++) chk($sformatf("random neuron %0d sum", n), sum[n], ref_sum[n]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dense_w2_seq.md
# dense_w2_seq

Read sequencer for the second dense layer's weight ROM. On a `start` pulse it walks every weight address once, neuron-major, driving the ROM's `ena`/`addr` pins. It emits MAC-side control aligned with the ROM's one-cycle read latency, so downstream accumulators consume `q` directly. It sits between the layer-level controller (`start`/`done`) and the dense_w2 weight ROM plus the dense MAC array, and it honours a downstream stall.

## Interface
- `ADDR_WIDTH`, default 8: ROM address width; matches the ROM instance.
- `N_IN`, default 16: input activations per neuron.
- `N_OUT`, default 10: neurons. Elaboration check: N_IN*N_OUT (plus N_OUT with bias) ≤ 2**ADDR_WIDTH.
- `IDX_W`, default 8: width of the index outputs.

Ports:
- `clk` in, 1: single clock; all logic on posedge.
- `rst_n` in, 1: asynchronous, active-low reset.
- `start` in, 1: one-cycle request to run the layer.
- `hold` in, 1: downstream stall; no new ROM read is issued while high.
- `busy` out, 1: high from the cycle after an accepted `start` until `done`.
- `done` out, 1: one-cycle completion pulse.
- `rom_ena` out, 1: drives ROM `ena`.
- `rom_addr` out, ADDR_WIDTH: drives ROM `addr`.
- `mac_valid` out, 1: ROM `q` is a valid weight this cycle.
- `mac_first` out, 1: with `mac_valid`, first weight of a neuron (clear accumulator).
- `mac_last` out, 1: with `mac_valid`, last term of a neuron.
- `act_idx` out, IDX_W: input-activation index for the current `q`.
- `neuron_idx` out, IDX_W: neuron index for the current `q`.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: `start`=1 moves to RUN and zeroes the input counter `i` and neuron counter `n`. `start` is ignored in every other state.
- RUN with `hold`=0:
  - `rom_ena`=1 and `rom_addr` = n*N_IN+i, kept as an incrementing address register (no multiplier).
  - `i` increments. At `i`=N_IN-1 it wraps to 0 and `n` increments.
  - After issuing the final address (n=N_OUT-1, i=N_IN-1), go to DRAIN.
- RUN with `hold`=1: `rom_ena`=0, counters frozen. The next issued address is the same un-issued one, so no read is lost or duplicated. The ROM returns 0 when `ena` is low, so `mac_valid` must be 0 in that cycle.
- DRAIN: `rom_ena`=0; the last read's `q` is presented with `mac_valid`=1 and `mac_last`=1. Always one cycle, `hold` is ignored. Then go to DONE.
- DONE: `done`=1 for one cycle, `busy`=0, then return to IDLE.
- Response pipeline: `mac_valid`, `mac_first`, `mac_last`, `act_idx` and `neuron_idx` are the issue-cycle values registered once, so they line up with ROM `q`.
- Reset (any state, including mid-run): FSM goes to IDLE. Every output and counter goes to 0: `busy`, `done`, `rom_ena`, `rom_addr`, `mac_*`, `act_idx`, `neuron_idx`. No `done` is produced for an aborted run.

## Timing
- `start` at cycle 0 with no hold:
  - `rom_ena` high in cycles 1..N, where N = N_IN*N_OUT.
  - `mac_valid` high in cycles 2..N+1.
  - `done` in cycle N+2.
  - `busy` high in cycles 1..N+1.
- Each `hold` cycle during RUN adds exactly one cycle to every later event.
- `hold` during IDLE, DRAIN or DONE has no effect.
- `start` in the same cycle as `done` is ignored. The earliest accepted restart is the cycle after `done`.

## Configuration
- `DENSE_W2_SEQ_BIAS_EN` defined: after each neuron's N_IN weight reads, one extra read is issued at address N_IN*N_OUT+n.
  - The bias read's response carries `mac_last`=1.
  - The final weight read of that neuron then has `mac_last`=0.
  - `act_idx` reports N_IN for the bias read.
  - Latency becomes N_OUT*(N_IN+1)+2 to `done`.
- Not defined: weight reads only. The final weight read carries `mac_last`.

## Structure
- A shared package `dense_pkg` holds:
  - the FSM state enum;
  - the default N_IN/N_OUT/ADDR_WIDTH constants for layer 2;
  - a function computing total reads (with and without bias).
- Sub-module `dense_w2_resp_pipe`: the one-stage register aligning `mac_*` and index outputs with ROM latency; it is reset by `rst_n`.
- The ROM itself is instantiated by the parent, not inside this block.

## Test plan
- Basic run, N_IN=4, N_OUT=2, no hold, start at cycle 0:
  - `rom_addr` sequence 0..7 in cycles 1..8;
  - `mac_first` at cycles 2 and 6, `mac_last` at cycles 5 and 9;
  - `done` at cycle 10.
- `hold`=1 in cycles 3–4 of the same run:
  - address 2 is issued at cycle 5, never skipped or repeated;
  - `mac_valid`=0 in cycles 4–5;
  - `done` at cycle 12.
- `start` re-pulsed while busy and again in the `done` cycle: both ignored, exactly one run completes.
- `rst_n` low at cycle 5 mid-run: all outputs are 0 within the same cycle. Restart after release gives a full address sequence from 0.
- `DENSE_W2_SEQ_BIAS_EN` with N_IN=4, N_OUT=2:
  - read order 0,1,2,3,8,4,5,6,7,9;
  - `mac_last` only on the responses to reads 8 and 9;
  - `done` at cycle 12.
- Default parameters, random `hold` at 30%, scoreboard against the ROM contents:
  - the sum of `q` per `neuron_idx` matches the reference dot-product;
  - `mac_valid` count = 160.
